// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, PC next-value
// selection, default geometry and the halt encoding used by the decoder.
package fetch_pkg;

  localparam int INSTR_W_DEF  = 9;
  localparam int ROM_SIZE_DEF = 256;

  // Instruction encoding that stops fetch; the decoder treats it the same way.
  localparam logic [INSTR_W_DEF-1:0] FETCH_HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2,
    PC_ZERO = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, ROM address/data and the instruction
// register handed to the decoder. master = fetch unit, slave = its environment.
// With FETCH_PERF_CNT_EN defined the bus also carries the performance counters.
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9
);

  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        cycle_cnt;
  logic [15:0]        instr_cnt;

  modport master (
    input  start, stall, branch_taken, branch_target, instr_in,
    output instr_addr, ir, ir_pc, ir_valid, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    output start, stall, branch_taken, branch_target, instr_in,
    input  instr_addr, ir, ir_pc, ir_valid, halted, cycle_cnt, instr_cnt
  );
`else
  modport master (
    input  start, stall, branch_taken, branch_target, instr_in,
    output instr_addr, ir, ir_pc, ir_valid, halted
  );

  modport slave (
    output start, stall, branch_taken, branch_target, instr_in,
    input  instr_addr, ir, ir_pc, ir_valid, halted
  );
`endif

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with hold / load-target / increment / clear
// selection. Increment wraps modulo 2^ADDR_W.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pc_sel_t           sel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next PC selection.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_HOLD: pc_d = pc_q;
      PC_LOAD: pc_d = target;
      PC_INC:  pc_d = pc_q + ADDR_W'(1);
      PC_ZERO: pc_d = '0;
      default: pc_d = pc_q;
    endcase
  end

  // PC register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the combinational ROM address, captures the returned
// word into the instruction register, and runs the IDLE/RUN/HALT control.
// Optional macro FETCH_PERF_CNT_EN adds saturating cycle/instruction counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  ROM_SIZE   = ROM_SIZE_DEF,
  parameter int                  INSTR_W    = INSTR_W_DEF,
  parameter int                  ADDR_W     = $clog2(ROM_SIZE),
  parameter logic [INSTR_W-1:0]  HALT_INSTR = FETCH_HALT_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t       state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic [ADDR_W-1:0]  ir_pc_d, ir_pc_q;
  logic               ir_valid_d, ir_valid_q;
  logic               halted_d, halted_q;
  pc_sel_t            pc_sel;
  logic [ADDR_W-1:0]  pc;
  logic               load_ir;
  logic               clr_cnt;

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (pc_sel),
    .target (bus.branch_target),
    .pc     (pc)
  );

  // Next-state, IR and PC-select logic; priority in RUN is
  // stall > branch > halt detect > sequential fetch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    pc_sel     = PC_HOLD;
    load_ir    = 1'b0;
    clr_cnt    = 1'b0;
    case (state_q)
      IDLE: begin
        pc_sel     = PC_ZERO;
        ir_valid_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          clr_cnt = 1'b1;
        end
      end
      RUN: begin
        if (bus.stall) begin
          pc_sel = PC_HOLD;
        end else if (bus.branch_taken) begin
          // Squash the wrong-path word sitting at the old PC.
          pc_sel     = PC_LOAD;
          ir_valid_d = 1'b0;
        end else begin
          load_ir    = 1'b1;
          ir_d       = bus.instr_in;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          if (bus.instr_in == HALT_INSTR) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_sel = PC_INC;
          end
        end
      end
      HALT: begin
        ir_valid_d = 1'b0;
        if (bus.start) begin
          pc_sel   = PC_ZERO;
          halted_d = 1'b0;
          state_d  = RUN;
          clr_cnt  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and instruction register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.instr_addr = pc;
  assign bus.ir         = ir_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_cnt_d, cycle_cnt_q;
  logic [15:0] instr_cnt_d, instr_cnt_q;

  // Saturating counters: RUN cycles and instructions delivered to ir.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (clr_cnt) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      if (state_q == RUN && cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
      if (load_ir && instr_cnt_q != 16'hFFFF)        instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(9)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: halt words at 18 and 30, otherwise addr ^ 8'h5A (top bit 0).
  function automatic logic [8:0] rv(input logic [7:0] a);
    if (a == 8'd18 || a == 8'd30) return 9'h1FF;
    return {1'b0, a ^ 8'h5A};
  endfunction

  assign bus.instr_in = rv(bus.instr_addr);

  typedef struct {
    logic       st, sl, br;
    logic [7:0] tgt;
    logic [7:0] e_addr;
    logic [8:0] e_ir;
    logic [7:0] e_pc;
    logic       e_v, e_h;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void v(input logic st, sl, br, input logic [7:0] tgt,
                            input logic [7:0] ea, input logic [8:0] eir,
                            input logic [7:0] epc, input logic ev, eh);
    vec_t x;
    x.st = st; x.sl = sl; x.br = br; x.tgt = tgt;
    x.e_addr = ea; x.e_ir = eir; x.e_pc = epc; x.e_v = ev; x.e_h = eh;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] ea, input logic [8:0] eir,
                          input logic [7:0] epc, input logic ev, eh);
    chk({tag, ".instr_addr"}, 32'(bus.instr_addr), 32'(ea));
    chk({tag, ".ir"},         32'(bus.ir),         32'(eir));
    chk({tag, ".ir_pc"},      32'(bus.ir_pc),      32'(epc));
    chk({tag, ".ir_valid"},   32'(bus.ir_valid),   32'(ev));
    chk({tag, ".halted"},     32'(bus.halted),     32'(eh));
  endtask

  task automatic drive(input logic st, sl, br, input logic [7:0] tgt);
    bus.start = st; bus.stall = sl; bus.branch_taken = br; bus.branch_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 8'd0);
    rst_n = 1'b0;

    // Idle after reset: 5 cycles with no start.
    for (int i = 0; i < 5; i++) v(0,0,0,8'd0,   8'd0,   9'd0,    8'd0,   0,0);
    // Start, then sequential fetch 0..3.
    v(1,0,0,8'd0,   8'd0,   9'd0,    8'd0,   0,0);
    v(0,0,0,8'd0,   8'd1,   rv(0),   8'd0,   1,0);
    v(0,0,0,8'd0,   8'd2,   rv(1),   8'd1,   1,0);
    v(0,0,0,8'd0,   8'd3,   rv(2),   8'd2,   1,0);
    v(0,0,0,8'd0,   8'd4,   rv(3),   8'd3,   1,0);
    // Stall three cycles at pc 4, then release.
    for (int i = 0; i < 3; i++) v(0,1,0,8'd0, 8'd4, rv(3), 8'd3, 1,0);
    v(0,0,0,8'd0,   8'd5,   rv(4),   8'd4,   1,0);
    // start ignored while running.
    v(1,0,0,8'd0,   8'd6,   rv(5),   8'd5,   1,0);
    v(0,0,0,8'd0,   8'd7,   rv(6),   8'd6,   1,0);
    v(0,0,0,8'd0,   8'd8,   rv(7),   8'd7,   1,0);
    v(0,0,0,8'd0,   8'd9,   rv(8),   8'd8,   1,0);
    // Branch at pc 9 to 17: bubble.
    v(0,0,1,8'd17,  8'd17,  rv(8),   8'd8,   0,0);
    // Stall wins over a pending branch.
    v(0,1,1,8'd40,  8'd17,  rv(8),   8'd8,   0,0);
    v(0,0,0,8'd0,   8'd18,  rv(17),  8'd17,  1,0);
    // Halt word at 18.
    v(0,0,0,8'd0,   8'd18,  9'h1FF,  8'd18,  1,1);
    v(0,0,0,8'd0,   8'd18,  9'h1FF,  8'd18,  0,1);
    v(0,0,0,8'd0,   8'd18,  9'h1FF,  8'd18,  0,1);
    // Restart from HALT.
    v(1,0,0,8'd0,   8'd0,   9'h1FF,  8'd18,  0,0);
    v(0,0,0,8'd0,   8'd1,   rv(0),   8'd0,   1,0);
    // Branch to 30 (a halt word), then branch away while it is on instr_in.
    v(0,0,1,8'd30,  8'd30,  rv(0),   8'd0,   0,0);
    v(0,0,1,8'd250, 8'd250, rv(0),   8'd0,   0,0);
    // Run up through 255 and wrap to 0.
    v(0,0,0,8'd0,   8'd251, rv(250), 8'd250, 1,0);
    v(0,0,0,8'd0,   8'd252, rv(251), 8'd251, 1,0);
    v(0,0,0,8'd0,   8'd253, rv(252), 8'd252, 1,0);
    v(0,0,0,8'd0,   8'd254, rv(253), 8'd253, 1,0);
    v(0,0,0,8'd0,   8'd255, rv(254), 8'd254, 1,0);
    v(0,0,0,8'd0,   8'd0,   rv(255), 8'd255, 1,0);
    v(0,0,0,8'd0,   8'd1,   rv(0),   8'd0,   1,0);
    // Branch to the current pc refetches it.
    v(0,0,1,8'd1,   8'd1,   rv(0),   8'd0,   0,0);
    v(0,0,0,8'd0,   8'd2,   rv(1),   8'd1,   1,0);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk_outs("reset", 8'd0, 9'd0, 8'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("reset.instr_cnt", 32'(bus.instr_cnt), 32'd0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tgt);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ir,
               vecs[i].e_pc, vecs[i].e_v, vecs[i].e_h);
    end

    // Advance pc 2 -> 12, then assert reset between clock edges.
    drive(0, 0, 0, 8'd0);
    repeat (10) tick();
    chk_outs("pre_reset", 8'd12, rv(11), 8'd11, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 8'd0, 9'd0, 8'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_reset.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("async_reset.instr_cnt", 32'(bus.instr_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_outs("post_reset_idle", 8'd0, 9'd0, 8'd0, 1'b0, 1'b0);

    // Start and run 10 unstalled RUN cycles.
    drive(1, 0, 0, 8'd0);
    tick();
    drive(0, 0, 0, 8'd0);
    repeat (10) tick();
    chk_outs("run10", 8'd10, rv(9), 8'd9, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("run10.cycle_cnt", 32'(bus.cycle_cnt), 32'd10);
    chk("run10.instr_cnt", 32'(bus.instr_cnt), 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch stage sitting directly upstream of the 9-bit instruction ROM. It drives the ROM address, captures the returned instruction into an instruction register for the decoder, and handles start/halt control. It also handles stall back-pressure and taken-branch redirects from downstream.
The ROM read is combinational, so the ROM returns the instruction at the current PC in the same cycle.

Parameters:
ROM_SIZE, 256, number of instruction words; must be a power of two
INSTR_W, 9, instruction width in bits
ADDR_W, $clog2(ROM_SIZE), PC / ROM address width
HALT_INSTR, 9'h1FF, encoding that stops fetch

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins execution at PC 0
stall  in  1  downstream not ready; freeze PC and IR
branch_taken  in  1  redirect request from decode/execute
branch_target  in  ADDR_W  absolute redirect address
instr_addr  out  ADDR_W  address to instruction ROM (equals PC)
instr_in  in  INSTR_W  instruction returned by ROM for instr_addr
ir  out  INSTR_W  registered instruction to decoder
ir_pc  out  ADDR_W  PC that ir was fetched from
ir_valid  out  1  ir holds a real instruction (not a bubble)
halted  out  1  HALT_INSTR reached; fetch stopped

Behaviour:
- Reset is asynchronous and active-low on rst_n; clocking is on clk rising edge. While asserted: pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, state=IDLE.
- State machine has three states: IDLE, RUN, HALT.
  - IDLE: pc held at 0, ir_valid=0. start -> RUN.
  - RUN, evaluated each cycle in priority order (stall > branch_taken > halt detect > normal):
    - stall=1: pc, ir, ir_pc, ir_valid all held. branch_taken is ignored; decode keeps it asserted.
    - branch_taken=1: pc<=branch_target and ir_valid<=0. This is a one-cycle bubble that squashes the wrong-path word at the old pc. Halt detection is suppressed on the squashed word.
    - instr_in==HALT_INSTR: ir<=instr_in, ir_pc<=pc, ir_valid<=1, pc held, halted<=1, state -> HALT.
    - otherwise: ir<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - HALT: ir_valid<=0 on the cycle after entry; pc, ir and halted held. start -> pc<=0, halted<=0, ir_valid<=0, state RUN.
- start is ignored in RUN.
- Latency: an instruction at address A appears on ir one cycle after instr_addr==A with no stall.
- Wrap-around: pc+1 from ROM_SIZE-1 wraps to 0. Arithmetic is modulo 2^ADDR_W. There is no error flag.
- A branch to the current pc is legal and refetches.
- Reset mid-operation aborts immediately to IDLE; no partial state survives.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[15:0] and instr_cnt[15:0].
  - cycle_cnt increments every cycle in RUN.
  - instr_cnt increments whenever ir_valid is loaded with 1.
  - Both saturate at 16'hFFFF, clear on reset and on an accepted start.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the state enum typedef fetch_state_t (IDLE, RUN, HALT)
  - localparam defaults for INSTR_W and ROM_SIZE
  - the HALT_INSTR constant, shared with the decoder
- One sub-module is natural: pc_reg, holding the PC register with hold / load-target / increment selection. The FSM and IR stay in fetch_unit.

Test Plan:
- Reset and start: rst_n low then high, no start for 5 cycles -> instr_addr=0, ir_valid=0. Pulse start -> instr_addr sequence 0,1,2 on consecutive cycles; ir=rom[0] one cycle after the start edge.
- Stall: stall=1 for 3 cycles while at pc=4 -> instr_addr stays 4; ir/ir_pc/ir_valid unchanged. Release stall -> pc 5 next cycle.
- Branch: branch_taken=1, branch_target=8'd17 at pc=9 -> next cycle instr_addr=17, ir_valid=0. Following cycle ir=rom[17], ir_pc=17, ir_valid=1.
- Halt: place 9'h1FF at address 18 -> ir=9'h1FF with ir_valid=1 and halted=1 the next cycle; pc stays 18. Subsequent start -> pc=0, halted=0.
- Branch vs halt and wrap: branch_taken while instr_in=9'h1FF -> no halt, redirect taken. With ROM_SIZE=256, reaching pc=255 without branch -> next pc=0.
- Async reset mid-run: drop rst_n between clock edges at pc=12 -> outputs zero immediately without a clock edge. With FETCH_PERF_CNT_EN, counters read 0; after 10 unstalled RUN cycles, cycle_cnt=10 and instr_cnt=10.
